// File: rtl/pb_debouncer_pkg.sv
// Shared types and timing helpers for the push-button debouncer.
package pb_debouncer_pkg;

  typedef enum logic [2:0] {
    INI       = 3'd0,
    WQ        = 3'd1,
    SCEN_ST   = 3'd2,
    WS        = 3'd3,
    MCEN_ST   = 3'd4,
    CCR       = 3'd5,
    MCEN_CONT = 3'd6,
    WFCR      = 3'd7
  } db_state_t;

  function automatic int unsigned t_db(input int unsigned n);
    return 32'd1 << (n - 3);
  endfunction

  function automatic int unsigned t_hold(input int unsigned n);
    return 32'd1 << (n - 1);
  endfunction

  function automatic int unsigned t_mc(input int unsigned n);
    return 32'd1 << (n - 2);
  endfunction

  // Output vector ordering is {DPB, SCEN, MCEN, CCEN}.
  function automatic logic [3:0] state_outputs(input db_state_t s);
    case (s)
      SCEN_ST:        return 4'b1111;
      WS, WFCR:       return 4'b1000;
      MCEN_ST:        return 4'b1011;
      CCR, MCEN_CONT: return 4'b1001;
      default:        return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/pb_sync2.sv
// Two-flop synchronizer with asynchronous reset for the raw button level.
// Only compiled when PB_DEBOUNCER_SYNC_EN is defined, since it is only instantiated then.
`ifdef PB_DEBOUNCER_SYNC_EN
module pb_sync2 (
  input  logic board_clk,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/pb_debouncer.sv
// Push-button debouncer producing DPB, SCEN, MCEN and CCEN with auto-repeat.
// Define PB_DEBOUNCER_SYNC_EN to insert the 2-flop input synchronizer.
module pb_debouncer
  import pb_debouncer_pkg::*;
#(
  parameter int N_dc = 25
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       PB,
  output logic       DPB,
  output logic       SCEN,
  output logic       MCEN,
  output logic       CCEN,
  output logic [2:0] state_dbg
);

  localparam logic [N_dc-1:0] DB_LAST   = N_dc'(t_db(N_dc) - 1);
  localparam logic [N_dc-1:0] HOLD_LAST = N_dc'(t_hold(N_dc) - 1);
  localparam logic [N_dc-1:0] MC_LAST   = N_dc'(t_mc(N_dc) - 1);
  localparam logic [N_dc-1:0] CNT_ONE   = N_dc'(1);

  logic            pb_s;
  db_state_t       state, state_nx;
  logic [N_dc-1:0] cnt, cnt_nx;

`ifdef PB_DEBOUNCER_SYNC_EN
  pb_sync2 u_sync (
    .board_clk (board_clk),
    .Reset     (Reset),
    .d         (PB),
    .q         (pb_s)
  );
`else
  assign pb_s = PB;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_ONE;
    case (state)
      INI: begin
        cnt_nx = '0;
        if (pb_s) state_nx = WQ;
      end
      WQ: begin
        if (!pb_s)              state_nx = INI;
        else if (cnt == DB_LAST) state_nx = SCEN_ST;
      end
      SCEN_ST: state_nx = WS;
      WS: begin
        if (!pb_s)                 state_nx = WFCR;
        else if (cnt == HOLD_LAST) state_nx = MCEN_ST;
      end
      MCEN_ST: state_nx = CCR;
      CCR: begin
        cnt_nx   = '0;
        state_nx = pb_s ? MCEN_CONT : WFCR;
      end
      MCEN_CONT: begin
        if (!pb_s)               state_nx = WFCR;
        else if (cnt == MC_LAST) state_nx = MCEN_ST;
      end
      WFCR: begin
        // Any high sample restarts the release-debounce window.
        if (pb_s)                cnt_nx   = '0;
        else if (cnt == DB_LAST) state_nx = INI;
      end
      default: state_nx = INI;
    endcase
    if (state_nx != state) cnt_nx = '0;
  end

  // Outputs are registered from the next state so they always track the state register.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state                  <= INI;
      cnt                    <= '0;
      {DPB, SCEN, MCEN, CCEN} <= 4'b0000;
    end else begin
      state                  <= state_nx;
      cnt                    <= cnt_nx;
      {DPB, SCEN, MCEN, CCEN} <= state_outputs(state_nx);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pb_debouncer.sv
// Self-checking bench for pb_debouncer: press/hold/release timeline model plus directed literals.
module tb_pb_debouncer;

  localparam int N_DC   = 6;
  localparam int T_DB   = 2 ** (N_DC - 3);
  localparam int T_HOLD = 2 ** (N_DC - 1);
  localparam int T_MC   = 2 ** (N_DC - 2);
`ifdef PB_DEBOUNCER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam int PH_IDLE = 0;
  localparam int PH_HELD = 1;
  localparam int PH_REL  = 2;

  logic       board_clk = 1'b0;
  logic       Reset     = 1'b0;
  logic       PB        = 1'b0;
  logic       DPB, SCEN, MCEN, CCEN;
  logic [2:0] state_dbg;

  pb_debouncer #(.N_dc(N_DC)) dut (
    .board_clk (board_clk),
    .Reset     (Reset),
    .PB        (PB),
    .DPB       (DPB),
    .SCEN      (SCEN),
    .MCEN      (MCEN),
    .CCEN      (CCEN),
    .state_dbg (state_dbg)
  );

  always #5 board_clk = ~board_clk;

  // Reference: idle until the button is seen high long enough, then a held
  // timeline (pulse at press, repeats after the hold time), then a release
  // window that needs T_DB uninterrupted low samples.
  int   m_phase, m_cnt, m_h;
  logic m_d1, m_d2;
  logic e_dpb, e_scen, e_mcen, e_ccen;

  always @(posedge board_clk or posedge Reset) begin : ref_model
    int   ph, cnt, h;
    logic p;
    if (Reset) begin
      m_phase <= PH_IDLE; m_cnt <= 0; m_h <= 0;
      m_d1 <= 1'b0; m_d2 <= 1'b0;
      e_dpb <= 1'b0; e_scen <= 1'b0; e_mcen <= 1'b0; e_ccen <= 1'b0;
    end else begin
      p   = (SYNC_LAT == 2) ? m_d2 : PB;
      ph  = m_phase;
      cnt = m_cnt;
      h   = m_h;
      if (m_phase == PH_IDLE) begin
        cnt = p ? cnt + 1 : 0;
        if (cnt == T_DB + 1) begin ph = PH_HELD; h = 0; cnt = 0; end
      end else if (m_phase == PH_HELD) begin
        // The one-cycle pulse states do not look at the button.
        if (!p && !e_mcen) begin ph = PH_REL; cnt = 0; end
        else h = h + 1;
      end else begin
        cnt = p ? 0 : cnt + 1;
        if (cnt == T_DB) begin ph = PH_IDLE; cnt = 0; end
      end
      m_d1 <= PB;
      m_d2 <= m_d1;
      m_phase <= ph;
      m_cnt <= cnt;
      m_h <= h;
      e_dpb  <= (ph != PH_IDLE);
      e_scen <= (ph == PH_HELD) && (h == 0);
      e_mcen <= (ph == PH_HELD) && (h == 0 ||
                (h >= T_HOLD + 1 && (h - (T_HOLD + 1)) % (T_MC + 2) == 0));
      e_ccen <= (ph == PH_HELD) && (h == 0 || h >= T_HOLD + 1);
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int dpb_cnt = 0, scen_cnt = 0, mcen_cnt = 0, ccen_cnt = 0;
  int last_scen_cyc = -1;
  int mcen_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: wait for the falling edge, compare against the model, gather statistics.
  task automatic tick();
    @(negedge board_clk);
    cyc++;
    n_checks++;
    if ({DPB, SCEN, MCEN, CCEN} !== {e_dpb, e_scen, e_mcen, e_ccen}) begin
      n_errors++;
      $display("FAIL cycle_cmp cyc=%0d dut{DPB,SCEN,MCEN,CCEN}=%b model=%b",
               cyc, {DPB, SCEN, MCEN, CCEN}, {e_dpb, e_scen, e_mcen, e_ccen});
    end
    if (DPB === 1'b1) dpb_cnt++;
    if (SCEN === 1'b1) begin scen_cnt++; last_scen_cyc = cyc; end
    if (MCEN === 1'b1) begin mcen_cnt++; mcen_q.push_back(cyc); end
    if (CCEN === 1'b1) ccen_cnt++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  int c0, s0, m0, cc0, d0, k0;

  initial begin
    #1 Reset = 1'b1;
    ticks(3);
    check("reset_outputs", {DPB, SCEN, MCEN, CCEN}, 0);
    check("reset_state", state_dbg, 0);
    #2 Reset = 1'b0;

    ticks(50);
    check("idle_dpb", dpb_cnt, 0);
    check("idle_scen", scen_cnt, 0);
    check("idle_state", state_dbg, 0);

    // Bounce: toggles every 3 cycles never survive the debounce window.
    s0 = scen_cnt; d0 = dpb_cnt; m0 = mcen_cnt; cc0 = ccen_cnt;
    for (int i = 0; i < 40; i++) begin
      PB = ((i / 3) % 2 == 0);
      tick();
    end
    PB = 1'b0;
    ticks(20);
    check("bounce_scen", scen_cnt - s0, 0);
    check("bounce_mcen", mcen_cnt - m0, 0);
    check("bounce_ccen", ccen_cnt - cc0, 0);
    check("bounce_dpb", dpb_cnt - d0, 0);

    // Clean press of 20 cycles.
    s0 = scen_cnt; d0 = dpb_cnt; m0 = mcen_cnt; cc0 = ccen_cnt;
    c0 = cyc; last_scen_cyc = -1;
    PB = 1'b1;
    ticks(20);
    PB = 1'b0;
    ticks(20);
    check("press_latency", last_scen_cyc - c0 - 1, T_DB + SYNC_LAT);
    check("press_scen", scen_cnt - s0, 1);
    check("press_mcen", mcen_cnt - m0, 1);
    check("press_ccen", ccen_cnt - cc0, 1);
    check("press_dpb_len", dpb_cnt - d0, 20);

    // Hold for 120 cycles: auto-repeat.
    s0 = scen_cnt; m0 = mcen_cnt; cc0 = ccen_cnt; k0 = mcen_q.size();
    PB = 1'b1;
    ticks(120);
    PB = 1'b0;
    ticks(30);
    check("hold_scen", scen_cnt - s0, 1);
    check("hold_mcen", mcen_cnt - m0, 6);
    check("hold_ccen", ccen_cnt - cc0, 80);
    if (mcen_q.size() >= k0 + 3) begin
      check("hold_gap1", mcen_q[k0 + 1] - mcen_q[k0], 33);
      check("hold_gap2", mcen_q[k0 + 2] - mcen_q[k0 + 1], 18);
    end else begin
      check("hold_mcen_present", mcen_q.size() - k0, 3);
    end

    // Short high glitch during the release window.
    s0 = scen_cnt; d0 = dpb_cnt;
    PB = 1'b1; ticks(20);
    PB = 1'b0; ticks(3);
    PB = 1'b1; ticks(3);
    PB = 1'b0; ticks(30);
    check("glitch_scen", scen_cnt - s0, 1);
    check("glitch_dpb_len", dpb_cnt - d0, 25);
    check("glitch_state", state_dbg, 0);

    // Reset while auto-repeating.
    PB = 1'b1;
    ticks(50);
    check("pre_reset_state", state_dbg, 6);
    #2 Reset = 1'b1;
    #1;
    check("async_reset_outputs", {DPB, SCEN, MCEN, CCEN}, 0);
    check("async_reset_state", state_dbg, 0);
    PB = 1'b0;
    ticks(3);
    #2 Reset = 1'b0;
    ticks(5);
    s0 = scen_cnt; c0 = cyc; last_scen_cyc = -1;
    PB = 1'b1;
    ticks(20);
    PB = 1'b0;
    ticks(20);
    check("post_reset_latency", last_scen_cyc - c0 - 1, T_DB + SYNC_LAT);
    check("post_reset_scen", scen_cnt - s0, 1);

    // Random level segments against the model.
    for (int seg = 0; seg < 80; seg++) begin
      PB = 1'($urandom_range(0, 1));
      ticks($urandom_range(1, 45));
    end
    PB = 1'b0;
    ticks(40);
    check("final_state", state_dbg, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
